// File: rtl/mem_responder.sv
// Unified instruction/data memory responder; optional misalignment checking under MEM_RESP_ALIGN_CHK_EN.
// Latency: IDT one edge after IAD; data ACK entered DWAIT+1 edges after MREQ is sampled.
// Backpressure: none; initiator holds request fields until ACKD_n low; one transaction at a time.
module mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int DWAIT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IAD,
    output logic [31:0] IDT,
    output logic        ACKI_n,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    output logic        ACKD_n,
    output logic        ERR
);

    localparam int          DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0]  DWAIT_CNT = 4'(DWAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ADDR_BITS+1:0] dad_q;
    logic [1:0]           size_q;
    logic                 wr_q;
    logic [31:0]          rdata_q;
    logic [31:0]          iad_q;

    logic                 access;
    logic                 misalign;
    logic                 mem_we;
    logic                 ddt_oe;
    logic [3:0]           be;
    logic [31:0]          wdata;
    logic [31:0]          rword;
    logic [31:0]          rdata_d;
    logic [4:0]           lane_sh;

    wire [ADDR_BITS-1:0] d_idx = dad_q[ADDR_BITS+1:2];
    wire [ADDR_BITS-1:0] i_idx = IAD[ADDR_BITS+1:2];

    // Upper data address bits are don't-care: the array wraps.
    logic unused_dad_hi;
    assign unused_dad_hi = ^DAD[31:ADDR_BITS+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MREQ) begin
                    state_d = S_WAIT;
                    cnt_d   = DWAIT_CNT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write data is replicated across lanes so byte enables alone select the target.
    always_comb begin
        rword   = mem[d_idx];
        lane_sh = {dad_q[1:0], 3'b000};
        be      = 4'hf;
        wdata   = DDT;
        rdata_d = rword;
        case (size_q)
            2'b00: begin
                be      = 4'b0001 << dad_q[1:0];
                wdata   = {4{DDT[7:0]}};
                rdata_d = {24'h0, rword[lane_sh +: 8]};
            end
            2'b01: begin
                be      = dad_q[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{DDT[15:0]}};
                rdata_d = {16'h0, (dad_q[1] ? rword[31:16] : rword[15:0])};
            end
            default: begin
                be      = 4'hf;
                wdata   = DDT;
                rdata_d = rword;
            end
        endcase
    end

`ifdef MEM_RESP_ALIGN_CHK_EN
    logic err_q;

    assign misalign = ((size_q == 2'b01) && dad_q[0]) ||
                      (size_q[1] && (dad_q[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (access && misalign) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign misalign = 1'b0;
    assign ERR      = 1'b0;
`endif

    assign mem_we = access && wr_q && !misalign;

    // Array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[d_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dad_q   <= '0;
            size_q  <= 2'b00;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && MREQ) begin
                dad_q  <= DAD[ADDR_BITS+1:0];
                size_q <= SIZE;
                wr_q   <= WRITE;
            end
            if (access && !wr_q) begin
                rdata_q <= misalign ? 32'h0 : rdata_d;
            end
        end
    end

    // Same-edge data write and fetch of one word: IDT sees the pre-write contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IDT    <= 32'h0;
            ACKI_n <= 1'b1;
            iad_q  <= 32'h0;
        end else begin
            IDT    <= mem[i_idx];
            ACKI_n <= (IAD != iad_q);
            iad_q  <= IAD;
        end
    end

    assign ACKD_n = (state_q != S_ACK);
    assign ddt_oe = (state_q == S_ACK) && !wr_q;
    assign DDT    = ddt_oe ? rdata_q : 32'bz;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: reset abort, lanes, latency, back-to-back, fetch port, alignment.
module tb_mem_responder;

    localparam int ADDR_BITS = 10;
    localparam int DWAIT     = 1;

`ifdef MEM_RESP_ALIGN_CHK_EN
    localparam logic [31:0] EXP_W20_AFTER_MIS = 32'hCAFEBABE;
    localparam logic [31:0] EXP_ERR_AFTER_MIS = 32'd1;
`else
    localparam logic [31:0] EXP_W20_AFTER_MIS = 32'h5A5A5A5A;
    localparam logic [31:0] EXP_ERR_AFTER_MIS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] IAD = 32'h0;
    logic [31:0] DAD = 32'h0;
    logic        MREQ = 1'b0;
    logic        WRITE = 1'b0;
    logic [1:0]  SIZE = 2'b00;
    logic [31:0] ddt_drv = 32'h0;
    logic        ddt_en = 1'b0;

    wire  [31:0] DDT;
    wire  [31:0] IDT;
    wire         ACKI_n;
    wire         ACKD_n;
    wire         ERR;

    assign DDT = ddt_en ? ddt_drv : 32'bz;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    int          lat;
    int          gap;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_BITS(ADDR_BITS), .DWAIT(DWAIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .IAD    (IAD),
        .IDT    (IDT),
        .ACKI_n (ACKI_n),
        .DAD    (DAD),
        .DDT    (DDT),
        .MREQ   (MREQ),
        .WRITE  (WRITE),
        .SIZE   (SIZE),
        .ACKD_n (ACKD_n),
        .ERR    (ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge on which ACKD_n is first seen low; lat counts negedges from request.
    task automatic bus_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rdata, output int latency);
        @(negedge clk);
        MREQ    = 1'b1;
        WRITE   = wr;
        SIZE    = sz;
        DAD     = addr;
        ddt_drv = wd;
        ddt_en  = wr;
        latency = 0;
        rdata   = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ACKD_n == 1'b0) begin
                latency = i;
                rdata   = DDT;
                break;
            end
        end
        MREQ   = 1'b0;
        ddt_en = 1'b0;
        check("ack_seen", 32'(latency != 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_idt",    IDT,               32'h0);
        check("rst_acki",   32'(ACKI_n),       32'd1);
        check("rst_ackd",   32'(ACKD_n),       32'd1);
        check("rst_err",    32'(ERR),          32'd0);
        check("rst_ddt_oe", 32'(dut.ddt_oe),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset with the write pending in WAIT must not commit it.
        bus_access(1'b1, 2'b10, 32'h10, 32'h12345678, rd, lat);
        @(negedge clk);
        MREQ = 1'b1; WRITE = 1'b1; SIZE = 2'b10; DAD = 32'h10;
        ddt_drv = 32'hDEADBEEF; ddt_en = 1'b1;
        repeat (DWAIT + 1) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ackd",   32'(ACKD_n),     32'd1);
        check("abort_ddt_oe", 32'(dut.ddt_oe), 32'd0);
        @(negedge clk);
        check("abort_ackd2",  32'(ACKD_n),     32'd1);
        MREQ = 1'b0; ddt_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_access(1'b0, 2'b10, 32'h10, 32'h0, rd, lat);
        check("abort_old_val", rd, 32'h12345678);

        bus_access(1'b1, 2'b10, 32'h20, 32'hCAFEBABE, rd, lat);
        check("wr_latency", 32'(lat), 32'(DWAIT + 2));
        bus_access(1'b0, 2'b10, 32'h20, 32'h0, rd, lat);
        check("rd_latency", 32'(lat), 32'(DWAIT + 2));
        check("rd_word20",  rd,       32'hCAFEBABE);
        @(negedge clk);
        check("ackd_idle",  32'(ACKD_n), 32'd1);

        bus_access(1'b1, 2'b10, 32'h40, 32'h11223344, rd, lat);
        bus_access(1'b1, 2'b00, 32'h41, 32'hFFFFFFAA, rd, lat);
        bus_access(1'b0, 2'b10, 32'h40, 32'h0, rd, lat);
        check("byte_wr_lane1", rd, 32'h1122AA44);
        bus_access(1'b0, 2'b01, 32'h42, 32'h0, rd, lat);
        check("half_rd_hi",    rd, 32'h00001122);
        bus_access(1'b0, 2'b00, 32'h41, 32'h0, rd, lat);
        check("byte_rd_lane1", rd, 32'h000000AA);
        bus_access(1'b1, 2'b10, 32'h44, 32'h0, rd, lat);
        bus_access(1'b1, 2'b01, 32'h46, 32'h5555BEEF, rd, lat);
        bus_access(1'b0, 2'b11, 32'h44, 32'h0, rd, lat);
        check("half_wr_hi",    rd, 32'hBEEF0000);

        // Back-to-back reads with MREQ held high across the first ACK.
        @(negedge clk);
        MREQ = 1'b1; WRITE = 1'b0; SIZE = 2'b10; DAD = 32'h20;
        rd1 = 32'h0; rd2 = 32'h0; gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ACKD_n == 1'b0) begin
                rd1 = DDT;
                break;
            end
        end
        DAD = 32'h40;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ACKD_n == 1'b0) begin
                gap = i - 1;
                rd2 = DDT;
                break;
            end
        end
        MREQ = 1'b0;
        check("b2b_rd1", rd1,        32'hCAFEBABE);
        check("b2b_rd2", rd2,        32'h1122AA44);
        check("b2b_gap", 32'(gap),   32'(DWAIT + 2));
        @(negedge clk);
        check("b2b_done", 32'(ACKD_n), 32'd1);

        bus_access(1'b1, 2'b10, 32'h0, 32'hA0A0A0A0, rd, lat);
        bus_access(1'b1, 2'b10, 32'h4, 32'hB1B1B1B1, rd, lat);
        @(negedge clk);
        IAD = 32'h0;
        repeat (2) @(negedge clk);
        check("if_hold0_idt",  IDT,          32'hA0A0A0A0);
        IAD = 32'h4;
        @(negedge clk);
        check("if_step_idt",   IDT,          32'hB1B1B1B1);
        check("if_step_acki",  32'(ACKI_n),  32'd1);
        @(negedge clk);
        check("if_hold_acki",  32'(ACKI_n),  32'd0);
        IAD = 32'h1000;
        @(negedge clk);
        check("if_wrap0_idt",  IDT,          32'hA0A0A0A0);
        check("if_wrap0_acki", 32'(ACKI_n),  32'd1);
        IAD = 32'h1004;
        @(negedge clk);
        check("if_wrap1_idt",  IDT,          32'hB1B1B1B1);
        IAD = 32'h6;
        @(negedge clk);
        check("if_lowbits_idt", IDT,         32'hB1B1B1B1);

        IAD = 32'h40;
        repeat (2) @(negedge clk);
        bus_access(1'b1, 2'b10, 32'h40, 32'h99999999, rd, lat);
        check("conflict_old", IDT, 32'h1122AA44);
        @(negedge clk);
        check("conflict_new", IDT, 32'h99999999);
        check("err_clear",    32'(ERR), 32'd0);

        bus_access(1'b1, 2'b10, 32'h22, 32'h5A5A5A5A, rd, lat);
        check("mis_wr_latency", 32'(lat), 32'(DWAIT + 2));
        bus_access(1'b0, 2'b10, 32'h20, 32'h0, rd, lat);
        check("mis_wr_word20",  rd,       EXP_W20_AFTER_MIS);
        check("mis_err",        32'(ERR), EXP_ERR_AFTER_MIS);
`ifdef MEM_RESP_ALIGN_CHK_EN
        bus_access(1'b0, 2'b01, 32'h41, 32'h0, rd, lat);
        check("mis_rd_zero",    rd,       32'h0);
`else
        bus_access(1'b0, 2'b01, 32'h41, 32'h0, rd, lat);
        check("half_rd_a0_ign", rd,       32'h00009999);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
